pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle fetch/PC sequencer for the lab CPU; the producing end of the immediate/target path.
- Owns the PC, fetches instructions over a req/ack handshake, and presents opcode, imm16, imm26 and npc to the immediate-extend stage.
- Consumes the resolved 32-bit branch/jump target and the taken/jump decision back from execute, then updates the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
HALT_OP, 6'b111111, opcode that parks the sequencer in HALT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held high until ack
imem_addr  out  32  fetch address (= pc while imem_req=1)
imem_ack  in  1  instruction memory ack; sampled only while imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
instr  out  32  latched instruction
instr_valid  out  1  one-cycle pulse: instr/fields/npc valid for decode
opcode  out  6  instr[31:26]
imm16  out  16  instr[15:0]
imm26  out  26  instr[25:0]
pc  out  32  address of current instruction
npc  out  32  pc+4, feeds the extend stage for target computation
exec_done  in  1  execute finished current instruction; sampled only in WAIT_EXEC
br_taken  in  1  branch taken, qualified by exec_done
jump  in  1  jump, qualified by exec_done
target  in  32  resolved branch/jump target, qualified by exec_done
halted  out  1  sequencer parked in HALT
misalign_err  out  1  sticky: redirect target had target[1:0]!=0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=RESET_PC; npc=RESET_PC+4; imem_req=0; instr=0; instr_valid=0; halted=0; misalign_err=0. imem_req drops immediately, including mid-fetch; a late ack after reset is ignored.
- Registered outputs: npc, instr, imem_req, instr_valid. opcode/imm16/imm26 are pure slices of instr. imem_addr = pc.
- States: IDLE, FETCH, ISSUE, WAIT_EXEC, HALT.
- IDLE: one cycle after reset release -> FETCH, with imem_req=1 on entry.
- FETCH: imem_req=1 and imem_addr stable until ack.
  - On imem_ack=1: latch instr<=imem_rdata, imem_req<=0, -> ISSUE.
  - No timeout; waits indefinitely.
- ISSUE: instr_valid=1 for exactly this cycle.
  - If opcode==HALT_OP: -> HALT.
  - Otherwise -> WAIT_EXEC unconditionally; exec_done in ISSUE is ignored.
- WAIT_EXEC: wait for exec_done=1, then apply one redirect rule with priority jump > br_taken > sequential:
  - jump=1: next pc=target.
  - else br_taken=1: next pc=target.
  - else: next pc=npc.
  - Any redirect with target[1:0]!=0: misalign_err<=1, pc unchanged, -> HALT.
  - Otherwise: pc<=next, npc<=next+4, -> FETCH with imem_req=1.
- HALT: halted=1, imem_req=0, instr_valid=0. Leaves only via reset; all inputs are ignored.
- Arithmetic: npc=pc+4 modulo 2^32, so pc=32'hFFFF_FFFC gives npc=32'h0000_0000 with no flag.
- Throughput: minimum 3 cycles/instruction (ack in first FETCH cycle, exec_done in first WAIT_EXEC cycle).
- Timing: instr_valid rises 1 cycle after the ack edge. The next imem_req rises on the edge that samples exec_done.
- Signals outside their qualifying state (imem_ack outside FETCH, exec_done/br_taken/jump/target outside WAIT_EXEC) have no effect.

Test Plan:
- Reset/sequential: RESET_PC=0, ack in first FETCH cycle with rdata 32'h2001_0005, exec_done with no branch -> instr_valid pulse with opcode=6'b001000 and imm16=16'h0005; pc 0->4->8 over successive instructions; npc=pc+4; 3 cycles/instruction.
- Branch vs jump priority: exec_done with br_taken=1, jump=1, target=32'h0000_0040 -> next imem_addr=32'h40; exec_done with br_taken=1 only, target=32'h100 -> imem_addr=32'h100.
- Handshake stall: ack delayed 5 cycles -> imem_req held high and imem_addr constant for 6 cycles; ack pulses outside FETCH do not change instr.
- Misaligned target: jump=1, target=32'h0000_0042 -> misalign_err=1 and halted=1; pc keeps its old value; imem_req stays 0 thereafter.
- Halt opcode and wrap: instruction 32'hFC00_0000 -> instr_valid pulse, then halted=1 permanently. Separately, pc=32'hFFFF_FFFC -> npc=0, and a sequential step gives imem_addr=0.
- Async reset mid-fetch: assert rst_n=0 while imem_req=1 (between clock edges) -> imem_req=0 in the same cycle; after release, 1 IDLE cycle, then fetch resumes at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/PC sequencer: fetches over req/ack, issues fields
// to the extend stage, and redirects the PC from execute's decision.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   imem_req/addr       fetch request and address (addr = pc)
//   imem_ack/rdata      fetch ack and instruction word
//   instr/instr_valid   latched instruction, one-cycle issue pulse
//   opcode/imm16/imm26  slices of instr
//   pc/npc              current instruction address, pc+4
//   exec_done/br_taken  execute completion and branch decision
//   jump/target         jump decision and resolved target
//   halted              parked in HALT until reset
//   misalign_err        sticky: redirect target not word aligned
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [31:0] pc,
  output logic [31:0] npc,
  input  logic        exec_done,
  input  logic        br_taken,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_EXEC,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        redir;
  logic [31:0] next_pc;

  // jump and taken branch both resolve to target
  assign redir   = jump | br_taken;
  assign next_pc = redir ? target : npc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_q[31:26] == HALT_OP) begin
          state_d = HALT;
        end else begin
          state_d = WAIT_EXEC;
        end
      end
      WAIT_EXEC: begin
        if (exec_done) begin
          if (redir && (target[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            npc_d   = next_pc + 32'd4;
            req_d   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      instr_q <= 32'h0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign opcode       = instr_q[31:26];
  assign imm16        = instr_q[15:0];
  assign imm26        = instr_q[25:0];
  assign pc           = pc_q;
  assign npc          = npc_q;
  assign halted       = (state_q == HALT);
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a transaction-level model of
// pc, instr, halt and error state checked every cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        exec_done;
  logic        br_taken;
  logic        jump;
  logic [31:0] target;
  logic        halted;
  logic        misalign_err;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .imm16        (imm16),
    .imm26        (imm26),
    .pc           (pc),
    .npc          (npc),
    .exec_done    (exec_done),
    .br_taken     (br_taken),
    .jump         (jump),
    .target       (target),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_halted;
  logic        m_err;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("npc", npc, m_pc + 32'd4);
      chk("instr", instr, m_instr);
      chk("opcode", {26'h0, opcode}, {26'h0, m_instr[31:26]});
      chk("imm16", {16'h0, imm16}, {16'h0, m_instr[15:0]});
      chk("imm26", {6'h0, imm26}, {6'h0, m_instr[25:0]});
      chk("halted", {31'h0, halted}, {31'h0, m_halted});
      chk("misalign", {31'h0, misalign_err}, {31'h0, m_err});
      if (m_halted) begin
        chk("halt_req", {31'h0, imem_req}, 32'h0);
        chk("halt_valid", {31'h0, instr_valid}, 32'h0);
      end
    end
  end

  task automatic model_reset();
    m_pc     = 32'h0;
    m_instr  = 32'h0;
    m_halted = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic clear_inputs();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    exec_done  = 1'b0;
    br_taken   = 1'b0;
    jump       = 1'b0;
    target     = 32'h0;
  endtask

  // Ends at the negedge of the first FETCH cycle.
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("fetch_req", {31'h0, imem_req}, 32'h1);
  endtask

  // From FETCH negedge to ISSUE negedge; ack after dly stall cycles.
  task automatic do_fetch(input int dly, input logic [31:0] word);
    for (int i = 0; i < dly; i++) begin
      chk("stall_req", {31'h0, imem_req}, 32'h1);
      chk("stall_addr", imem_addr, m_pc);
      imem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk("ack_req", {31'h0, imem_req}, 32'h1);
    chk("ack_addr", imem_addr, m_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk);
    m_instr = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("issue_valid", {31'h0, instr_valid}, 32'h1);
    chk("issue_req", {31'h0, imem_req}, 32'h0);
  endtask

  // From ISSUE negedge to the negedge after exec_done is sampled.
  task automatic do_exec(input int dly, input logic br, input logic jmp,
                         input logic [31:0] tgt);
    // stray execute and ack inputs during ISSUE must be ignored
    exec_done  = 1'b1;
    jump       = 1'b1;
    target     = 32'h0000_0200;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0001;
    @(posedge clk);
    @(negedge clk);
    chk("wait_valid", {31'h0, instr_valid}, 32'h0);
    for (int i = 0; i < dly; i++) begin
      chk("wait_req", {31'h0, imem_req}, 32'h0);
      exec_done = 1'b0;
      jump      = 1'b0;
      imem_ack  = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    br_taken  = br;
    jump      = jmp;
    target    = tgt;
    @(posedge clk);
    if ((br || jmp) && (tgt[1:0] != 2'b00)) begin
      m_err    = 1'b1;
      m_halted = 1'b1;
    end else if (br || jmp) begin
      m_pc = tgt;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
    clear_inputs();
    chk("next_req", {31'h0, imem_req}, {31'h0, !m_halted});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    model_reset();
    reset_dut();
    chk("rst_pc", pc, 32'h0);
    chk("rst_npc", npc, 32'h4);
    chk("rst_instr", instr, 32'h0);
    mon_en = 1'b1;

    // sequential
    do_fetch(0, 32'h2001_0005);
    chk("lit_opcode", {26'h0, opcode}, 32'h8);
    chk("lit_imm16", {16'h0, imm16}, 32'h5);
    do_exec(0, 1'b0, 1'b0, 32'h0);
    chk("lit_addr4", imem_addr, 32'h4);
    do_fetch(0, 32'h0000_0010);
    do_exec(1, 1'b0, 1'b0, 32'h0000_0080);
    chk("lit_addr8", imem_addr, 32'h8);
    chk("lit_npc8", npc, 32'hC);

    // priority
    do_fetch(0, 32'h1000_0000);
    do_exec(0, 1'b1, 1'b1, 32'h0000_0040);
    chk("lit_jmp40", imem_addr, 32'h40);
    do_fetch(2, 32'h1400_0003);
    do_exec(0, 1'b1, 1'b0, 32'h0000_0100);
    chk("lit_br100", imem_addr, 32'h100);

    // stall then wrap
    do_fetch(5, 32'h0800_0000);
    do_exec(3, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("lit_pcFFC", pc, 32'hFFFF_FFFC);
    chk("lit_npc0", npc, 32'h0);
    do_fetch(0, 32'h0000_0000);
    do_exec(0, 1'b0, 1'b0, 32'h0000_0003);
    chk("lit_wrap", imem_addr, 32'h0);

    // misaligned redirect
    do_fetch(1, 32'h0C00_0001);
    do_exec(0, 1'b0, 1'b1, 32'h0000_0042);
    chk("lit_mis_err", {31'h0, misalign_err}, 32'h1);
    chk("lit_mis_halt", {31'h0, halted}, 32'h1);
    chk("lit_mis_pc", pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      imem_ack  = 1'b1;
      exec_done = 1'b1;
      jump      = 1'b1;
      target    = 32'h0000_0100;
      @(posedge clk);
      @(negedge clk);
      chk("mis_req", {31'h0, imem_req}, 32'h0);
    end
    clear_inputs();

    // halt opcode
    reset_dut();
    do_fetch(0, 32'hFC00_0000);
    chk("lit_haltop", {26'h0, opcode}, 32'h3F);
    @(posedge clk);
    m_halted = 1'b1;
    @(negedge clk);
    chk("lit_halted", {31'h0, halted}, 32'h1);
    chk("lit_halt_err", {31'h0, misalign_err}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      imem_ack  = 1'b1;
      exec_done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("halt_req", {31'h0, imem_req}, 32'h0);
    end
    clear_inputs();

    // async reset mid-fetch with a late ack
    reset_dut();
    do_fetch(0, 32'h2002_0010);
    do_exec(0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_req", {31'h0, imem_req}, 32'h0);
    chk("async_pc", pc, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    rst_n = 1'b1;
    chk("late_idle_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_instr", instr, 32'h0);
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h0);
    do_fetch(0, 32'h2003_0007);
    chk("lit_resume_imm", {16'h0, imm16}, 32'h7);
    do_exec(0, 1'b0, 1'b0, 32'h0);
    chk("lit_resume4", imem_addr, 32'h4);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             errors);
    $finish;
  end

endmodule
